timer_div_tima: RTL and testbench

- Cycle-accurate DIV/TIMA/TMA/TAC timer at 0xFF04-0xFF07; directly upstream of the interrupt block.
- Produces int_timer, the timer interrupt request; the interrupt block's IF bit 2 flop sets on its rising edge.
- Clocked once per machine cycle on boga1mhz.
- Also provides a divider tap for the APU frame sequencer.

---
 rtl/timer_div_tima.sv | 169 ++++++++++++++++
 tb/tb_timer_div_tima.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_div_tima.sv
`default_nettype none
// ============================================================================
//  Module   : timer_div_tima
//  Purpose  : DIV/TIMA/TMA/TAC timer at FF04-FF07, clocked once per machine
//             cycle. Raises int_timer for one cycle when TIMA is reloaded and
//             optionally provides a DIV-derived tick for the APU frame
//             sequencer.
//  Options  : TIMER_APU_TICK_EN - build the cnt[10] falling-edge tick;
//             when undefined apu_tick is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_div_tima #(
  parameter int                 CNT_W     = 14,
  parameter logic [CNT_W-1:0]   DIV_RESET = '0
) (
  input  logic       boga1mhz,
  input  logic       reset2,
  inout  wire  [7:0] d,
  input  logic       nff04_wr,
  input  logic       nff05_wr,
  input  logic       nff06_wr,
  input  logic       nff07_wr,
  input  logic       nff04_rd,
  input  logic       nff05_rd,
  input  logic       nff06_rd,
  input  logic       nff07_rd,
  output logic       int_timer,
  output logic       apu_tick
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tima;
  logic [7:0]       tima_next;
  logic [7:0]       tma;
  logic [7:0]       tma_new;
  logic [2:0]       tac;
  logic             tin;
  logic             tin_q;
  logic             sel_bit;
  logic             inc;
  logic [7:0]       rd_data;
  logic             rd_any;

  logic wr_div, wr_tima, wr_tma, wr_tac;
  assign wr_div  = ~nff04_wr;
  assign wr_tima = ~nff05_wr;
  assign wr_tma  = ~nff06_wr;
  assign wr_tac  = ~nff07_wr;

  // Free-running divider; any DIV write clears it regardless of data.
  always_ff @(posedge boga1mhz) begin
    if (reset2)      cnt <= DIV_RESET;
    else if (wr_div) cnt <= '0;
    else             cnt <= cnt + CNT_W'(1);
  end

  // Divider tap chosen by TAC[1:0], gated by the TAC enable bit.
  always_comb begin
    case (tac[1:0])
      2'b00:   sel_bit = cnt[7];
      2'b01:   sel_bit = cnt[1];
      2'b10:   sel_bit = cnt[3];
      default: sel_bit = cnt[5];
    endcase
  end

  assign tin = tac[2] & sel_bit;
  // A falling edge from any cause (count, DIV write, TAC write) ticks TIMA.
  assign inc = tin_q & ~tin;

  // Edge-detect history plus the TMA and TAC registers.
  always_ff @(posedge boga1mhz) begin
    if (reset2) begin
      tin_q <= 1'b0;
      tma   <= 8'h00;
      tac   <= 3'b000;
    end else begin
      tin_q <= tin;
      if (wr_tma) tma <= d;
      if (wr_tac) tac <= d[2:0];
    end
  end

  // TMA as it will be after this edge, so a same-cycle TMA write reaches TIMA.
  assign tma_new = wr_tma ? d : tma;

  // Reload FSM state and TIMA register.
  always_ff @(posedge boga1mhz) begin
    if (reset2) begin
      state <= ST_IDLE;
      tima  <= 8'h00;
    end else begin
      state <= state_next;
      tima  <= tima_next;
    end
  end

  // Next-state / TIMA update: overflow reads 00 for one cycle, then TMA.
  always_comb begin
    state_next = state;
    tima_next  = tima;
    case (state)
      ST_IDLE: begin
        if (wr_tima) begin
          tima_next = d;
        end else if (inc) begin
          tima_next = tima + 8'd1;
          if (tima == 8'hFF) state_next = ST_OVF;
        end
      end
      ST_OVF: begin
        if (wr_tima) begin
          tima_next  = d;
          state_next = ST_IDLE;
        end else begin
          tima_next  = tma_new;
          state_next = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        // TIMA writes are lost here; TIMA tracks TMA including a new write.
        tima_next  = tma_new;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign int_timer = (state == ST_RELOAD);

  // Read mux; unused TAC bits read as ones.
  always_comb begin
    rd_data = 8'h00;
    rd_any  = 1'b1;
    if (!nff04_rd)      rd_data = cnt[CNT_W-1:CNT_W-8];
    else if (!nff05_rd) rd_data = tima;
    else if (!nff06_rd) rd_data = tma;
    else if (!nff07_rd) rd_data = {5'b11111, tac};
    else                rd_any  = 1'b0;
  end

  assign d = rd_any ? rd_data : 8'hzz;

`ifdef TIMER_APU_TICK_EN
  logic cnt10_q;

  // History of divider bit 10 for the APU frame-sequencer tick.
  always_ff @(posedge boga1mhz) begin
    if (reset2) cnt10_q <= DIV_RESET[10];
    else        cnt10_q <= cnt[10];
  end

  assign apu_tick = cnt10_q & ~cnt[10];
`else
  assign apu_tick = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_div_tima.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_div_tima
//  Purpose  : Directed self-checking bench for timer_div_tima.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_div_tima;

  logic       clk;
  logic       reset2;
  logic [3:0] nwr;
  logic [3:0] nrd;
  logic       d_oe;
  logic [7:0] d_drv;
  wire  [7:0] d;
  logic       int_timer;
  logic       apu_tick;
  int         n_tests;
  int         n_fail;

  assign d = d_oe ? d_drv : 8'hzz;

  timer_div_tima dut (
    .boga1mhz  (clk),
    .reset2    (reset2),
    .d         (d),
    .nff04_wr  (nwr[0]),
    .nff05_wr  (nwr[1]),
    .nff06_wr  (nwr[2]),
    .nff07_wr  (nwr[3]),
    .nff04_rd  (nrd[0]),
    .nff05_rd  (nrd[1]),
    .nff06_rd  (nrd[2]),
    .nff07_rd  (nrd[3]),
    .int_timer (int_timer),
    .apu_tick  (apu_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Register index: 0=DIV 1=TIMA 2=TMA 3=TAC
  task automatic wr(input int a, input logic [7:0] v);
    nwr[a] = 1'b0;
    d_oe   = 1'b1;
    d_drv  = v;
    step();
    nwr[a] = 1'b1;
    d_oe   = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    nrd[a] = 1'b0;
    #1;
    v = d;
    nrd[a] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // Quiesce, load TMA/TIMA, clear DIV, then enable TAC=05 at cnt=0.
  // Afterwards TIMA increments 4, 8, 12, ... cycles later.
  task automatic setup(input logic [7:0] tma_v, input logic [7:0] tima_v);
    wr(3, 8'h00);
    wr(2, tma_v);
    wr(1, tima_v);
    wr(0, 8'h00);
    wr(3, 8'h05);
  endtask

  initial begin
    int ticks;
    logic [7:0] exp_tick;
    n_tests = 0;
    n_fail  = 0;
    nwr     = 4'hF;
    nrd     = 4'hF;
    d_oe    = 1'b0;
    d_drv   = 8'h00;
    reset2  = 1'b1;
    steps(2);
    reset2  = 1'b0;

    // Reset state
    chk("rst_int", {7'd0, int_timer}, 8'h00);
    chk("rst_apu", {7'd0, apu_tick}, 8'h00);
    chk_rd("rst_div", 0, 8'h00);
    chk_rd("rst_tima", 1, 8'h00);
    chk_rd("rst_tma", 2, 8'h00);
    chk_rd("rst_tac", 3, 8'hF8);

    // TAC=05 from reset: 4-cycle tick
    wr(3, 8'h05);
    chk_rd("tac_rd", 3, 8'hFD);
    steps(3);
    chk_rd("s1_tima_k3", 1, 8'h00);
    step();
    chk_rd("s1_tima_k4", 1, 8'h01);
    steps(11);
    chk_rd("s1_tima_k15", 1, 8'h03);
    step();
    chk_rd("s1_tima_k16", 1, 8'h04);

    // Overflow and reload from TMA=AB
    setup(8'hAB, 8'hFF);
    chk_rd("s2_tima_k0", 1, 8'hFF);
    steps(3);
    chk_rd("s2_tima_k3", 1, 8'hFF);
    chk("s2_int_k3", {7'd0, int_timer}, 8'h00);
    step();
    chk_rd("s2_tima_ovf", 1, 8'h00);
    chk("s2_int_ovf", {7'd0, int_timer}, 8'h00);
    step();
    chk_rd("s2_tima_reload", 1, 8'hAB);
    chk("s2_int_reload", {7'd0, int_timer}, 8'h01);
    step();
    chk_rd("s2_tima_after", 1, 8'hAB);
    chk("s2_int_after", {7'd0, int_timer}, 8'h00);

    // TIMA write during the OVF cycle cancels reload and interrupt
    setup(8'hAB, 8'hFF);
    steps(4);
    chk_rd("s3_tima_ovf", 1, 8'h00);
    wr(1, 8'h42);
    chk_rd("s3_tima_wr", 1, 8'h42);
    chk("s3_int_k5", {7'd0, int_timer}, 8'h00);
    step();
    chk("s3_int_k6", {7'd0, int_timer}, 8'h00);
    chk_rd("s3_tima_k6", 1, 8'h42);
    steps(2);
    chk_rd("s3_tima_k8", 1, 8'h43);

    // TIMA write during RELOAD is ignored
    setup(8'hAB, 8'hFF);
    steps(5);
    chk("s4a_int_reload", {7'd0, int_timer}, 8'h01);
    wr(1, 8'h11);
    chk_rd("s4a_tima", 1, 8'hAB);
    chk("s4a_int_after", {7'd0, int_timer}, 8'h00);

    // TMA write during RELOAD reaches TIMA too
    setup(8'hAB, 8'hFF);
    steps(5);
    chk("s4b_int_reload", {7'd0, int_timer}, 8'h01);
    wr(2, 8'h77);
    chk_rd("s4b_tma", 2, 8'h77);
    chk_rd("s4b_tima", 1, 8'h77);

    // DIV write drops cnt[7] with TAC=04 -> glitch increment
    wr(3, 8'h00);
    wr(2, 8'h00);
    wr(1, 8'h10);
    wr(0, 8'h00);
    wr(3, 8'h04);
    steps(199);
    chk_rd("s5_div_200", 0, 8'h03);
    chk_rd("s5_tima_pre", 1, 8'h10);
    wr(0, 8'h5A);
    chk_rd("s5_div_clr", 0, 8'h00);
    chk_rd("s5_tima_e0", 1, 8'h10);
    step();
    chk_rd("s5_tima_e1", 1, 8'h11);
    steps(62);
    chk_rd("s5_div_63", 0, 8'h00);
    step();
    chk_rd("s5_div_64", 0, 8'h01);
    chk_rd("s5_tima_64", 1, 8'h11);

    // Reset during RELOAD drops the interrupt
    setup(8'hAB, 8'hFF);
    steps(5);
    chk("s6_int_pre", {7'd0, int_timer}, 8'h01);
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    chk("s6_int_rst", {7'd0, int_timer}, 8'h00);
    chk_rd("s6_tima", 1, 8'h00);
    chk_rd("s6_tma", 2, 8'h00);
    chk_rd("s6_tac", 3, 8'hF8);
    chk_rd("s6_div", 0, 8'h00);
    step();
    chk("s6_int_next", {7'd0, int_timer}, 8'h00);

    // Free run from reset: APU tick on cnt[10] falling (2048, 4096)
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
`ifdef TIMER_APU_TICK_EN
    exp_tick = 8'h01;
`else
    exp_tick = 8'h00;
`endif
    ticks = 0;
    for (int k = 1; k <= 4100; k++) begin
      step();
      if (apu_tick) ticks++;
      if (k == 2047) chk("apu_k2047", {7'd0, apu_tick}, 8'h00);
      if (k == 2048) begin
        chk("apu_k2048", {7'd0, apu_tick}, exp_tick);
        chk_rd("div_k2048", 0, 8'h20);
      end
      if (k == 2049) chk("apu_k2049", {7'd0, apu_tick}, 8'h00);
      if (k == 4096) chk("apu_k4096", {7'd0, apu_tick}, exp_tick);
    end
    chk("apu_count", 8'(ticks), exp_tick << 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
